// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared encodings, states and BSR layout for the BIST sequencer
package bist_pkg;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'b00,
    OP_RUN      = 2'b01,
    OP_SETSTATE = 2'b10,
    OP_ABORT    = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_UPD,
    ST_LOAD_HOLD,
    ST_RUN_ARM,
    ST_RUN_WAIT,
    ST_RUN_END,
    ST_SET_UPD
  } state_e;

  localparam int BSR_CFG_HI = 9;
  localparam int BSR_CFG_LO = 6;
  localparam int BSR_CHK_HI = 5;
  localparam int BSR_CHK_LO = 2;

  localparam logic [7:0] CLEAN_FINISH = 8'hFF;

  function automatic logic [9:0] bsr_word(input logic [3:0] cfg, input logic [3:0] chk);
    logic [9:0] w;
    w = '0;
    w[BSR_CFG_HI:BSR_CFG_LO] = cfg;
    w[BSR_CHK_HI:BSR_CHK_LO] = chk;
    return w;
  endfunction

endpackage

// File: rtl/bist_seq_ctrl_if.sv
// rtl/bist_seq_ctrl_if.sv - host command channel into the BIST sequencer
interface bist_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/bist_run_timer.sv
// rtl/bist_run_timer.sv - loadable up-counter flagging the RUN watchdog limit
module bist_run_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic TLR,
  input  logic i_load,
  input  logic i_en,
  output logic o_terminal
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (TLR)         r_count <= '0;
    else if (i_load) r_count <= '0;
    else if (i_en)   r_count <= r_count + 1'b1;
  end

  assign o_terminal = (r_count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/bist_seq_ctrl.sv
// rtl/bist_seq_ctrl.sv - command-driven sequencer driving the BIST engine selects and BSR
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int  DEPTH   = 256,
  parameter int  TIMEOUT = 4096,
  localparam int WIDTH   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 TLR,
  bist_seq_ctrl_if.slave       cmd,
  output logic                 RUNBIST_SELECT,
  output logic                 GETTEST_SELECT,
  output logic                 SETSTATE_SELECT,
  output logic                 UPDATEDR,
  output logic [9:0]           BSR,
  input  logic                 RESET_SM,
  input  logic                 error,
  input  logic [7:0]           BIST_DATA,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           fail_index,
  output logic                 timeout,
  output logic [WIDTH:0]       vec_count,
  output logic                 cmd_err
);
  localparam logic [WIDTH:0] VEC_FULL = (WIDTH+1)'(DEPTH);

  state_e  r_state, w_next;
  cmd_op_e w_op;
  logic    w_accept, w_load_ok, w_run_ok, w_set_ok, w_reject;
  logic    w_timer_load, w_timer_en, w_timer_term;
  logic    r_err_seen;

  assign w_op     = cmd_op_e'(cmd.cmd_op);
  assign w_accept = cmd.cmd_valid & cmd.cmd_ready;

  bist_run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk        (clk),
    .TLR        (TLR),
    .i_load     (w_timer_load),
    .i_en       (w_timer_en),
    .o_terminal (w_timer_term)
  );

  always_ff @(posedge clk) begin
    if (TLR) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    cmd.cmd_ready   = 1'b0;
    busy            = 1'b1;
    RUNBIST_SELECT  = 1'b0;
    GETTEST_SELECT  = 1'b0;
    SETSTATE_SELECT = 1'b0;
    UPDATEDR        = 1'b0;
    done            = 1'b0;
    w_load_ok       = 1'b0;
    w_run_ok        = 1'b0;
    w_set_ok        = 1'b0;
    w_reject        = 1'b0;
    w_timer_load    = 1'b0;
    w_timer_en      = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD_HOLD: begin
        cmd.cmd_ready  = 1'b1;
        busy           = 1'b0;
        // holding GETTEST keeps the engine's write pointer between LOADs
        GETTEST_SELECT = (r_state == ST_LOAD_HOLD);
        if (w_accept) begin
          case (w_op)
            OP_LOAD: begin
              if (r_state == ST_LOAD_HOLD && vec_count == VEC_FULL) w_reject = 1'b1;
              else begin
                w_load_ok = 1'b1;
                w_next    = ST_LOAD_UPD;
              end
            end
            OP_RUN: begin
              if (vec_count == '0) w_reject = 1'b1;
              else begin
                w_run_ok = 1'b1;
                w_next   = ST_RUN_ARM;
              end
            end
            OP_SETSTATE: begin
              w_set_ok = 1'b1;
              w_next   = ST_SET_UPD;
            end
            OP_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_UPD: begin
        GETTEST_SELECT = 1'b1;
        UPDATEDR       = 1'b1;
        w_next         = ST_LOAD_HOLD;
      end
      ST_RUN_ARM: begin
        RUNBIST_SELECT = 1'b1;
        w_timer_load   = 1'b1;
        w_next         = ST_RUN_WAIT;
      end
      ST_RUN_WAIT: begin
        RUNBIST_SELECT = 1'b1;
        w_timer_en     = 1'b1;
        if (RESET_SM || w_timer_term) w_next = ST_RUN_END;
      end
      ST_RUN_END: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      ST_SET_UPD: begin
        SETSTATE_SELECT = 1'b1;
        UPDATEDR        = 1'b1;
        w_next          = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (TLR) begin
      BSR        <= '0;
      vec_count  <= '0;
      pass       <= 1'b0;
      fail_index <= CLEAN_FINISH;
      timeout    <= 1'b0;
      cmd_err    <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      cmd_err <= w_reject;
      if (w_load_ok) begin
        BSR <= bsr_word(cmd.cmd_data[7:4], cmd.cmd_data[3:0]);
        if (r_state == ST_IDLE) vec_count <= '0;
      end
      if (r_state == ST_LOAD_UPD) vec_count <= vec_count + 1'b1;
      if (w_set_ok) BSR <= bsr_word(cmd.cmd_data[3:0], 4'h0);
      if (w_run_ok) begin
        pass       <= 1'b0;
        timeout    <= 1'b0;
        fail_index <= CLEAN_FINISH;
        r_err_seen <= 1'b0;
      end
      if (r_state == ST_RUN_WAIT) begin
        if (error && !r_err_seen) begin
          fail_index <= BIST_DATA;
          r_err_seen <= 1'b1;
        end
        // a finish landing on the watchdog limit still counts as completion
        if (!RESET_SM && w_timer_term) timeout <= 1'b1;
      end
      if (r_state == ST_RUN_END)
        pass <= !timeout && (fail_index == CLEAN_FINISH) && !error;
    end
  end
endmodule

// File: tb/tb_bist_seq_ctrl.sv
// tb/tb_bist_seq_ctrl.sv - directed/randomised bench for bist_seq_ctrl
module tb_bist_seq_ctrl;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       TLR;
  logic       RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT, UPDATEDR;
  logic [9:0] BSR;
  logic       RESET_SM, error;
  logic [7:0] BIST_DATA;
  logic       busy, done, pass, timeout, cmd_err;
  logic [7:0] fail_index;
  logic [3:0] vec_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_vec  = 0;

  always #5 clk = ~clk;

  bist_seq_ctrl_if cif();

  bist_seq_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .TLR             (TLR),
    .cmd             (cif),
    .RUNBIST_SELECT  (RUNBIST_SELECT),
    .GETTEST_SELECT  (GETTEST_SELECT),
    .SETSTATE_SELECT (SETSTATE_SELECT),
    .UPDATEDR        (UPDATEDR),
    .BSR             (BSR),
    .RESET_SM        (RESET_SM),
    .error           (error),
    .BIST_DATA       (BIST_DATA),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_index      (fail_index),
    .timeout         (timeout),
    .vec_count       (vec_count),
    .cmd_err         (cmd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int guard;
    guard = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = d;
    while (cif.cmd_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    chk("ready_wait", 32'(guard < 40), 32'h1);
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    TLR = 1'b1;
    tick();
    tick();
    TLR = 1'b0;
    exp_vec = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rb"},   32'(RUNBIST_SELECT), 32'h0);
    chk({tag, "_gt"},   32'(GETTEST_SELECT), 32'h0);
    chk({tag, "_ss"},   32'(SETSTATE_SELECT), 32'h0);
    chk({tag, "_upd"},  32'(UPDATEDR), 32'h0);
    chk({tag, "_bsr"},  32'(BSR), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"},  32'(cmd_err), 32'h0);
    chk({tag, "_to"},   32'(timeout), 32'h0);
    chk({tag, "_vec"},  32'(vec_count), 32'h0);
    chk({tag, "_pass"}, 32'(pass), 32'h0);
    chk({tag, "_fi"},   32'(fail_index), 32'hFF);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // LOAD from IDLE or LOAD_HOLD: one strobe cycle then hold
  task automatic do_load(input logic [7:0] d, input string tag);
    send(2'b00, d);
    exp_vec++;
    chk({tag, "_upd"}, 32'(UPDATEDR), 32'h1);
    chk({tag, "_gt"},  32'(GETTEST_SELECT), 32'h1);
    chk({tag, "_bsr"}, 32'(BSR), 32'((d * 4) % 1024));
    tick();
    chk({tag, "_upd0"}, 32'(UPDATEDR), 32'h0);
    chk({tag, "_gth"},  32'(GETTEST_SELECT), 32'h1);
    chk({tag, "_vec"},  32'(vec_count), 32'(exp_vec));
  endtask

  // engine drives RESET_SM on RUN_WAIT cycle len-1 if fin; errors on cycles e1/e2
  task automatic do_run(input int len, input int e1, input logic [7:0] d1,
                        input int e2, input logic [7:0] d2, input bit fin, input string tag);
    int         waits;
    bit         exp_to;
    logic [7:0] exp_fi;
    int         first_at;
    exp_to   = !(fin && len <= TIMEOUT);
    waits    = exp_to ? TIMEOUT : len;
    exp_fi   = 8'hFF;
    first_at = waits;
    if (e1 >= 0 && e1 < first_at) begin first_at = e1; exp_fi = d1; end
    if (e2 >= 0 && e2 < first_at) begin first_at = e2; exp_fi = d2; end
    send(2'b01, 8'($urandom));
    for (int e = 1; e <= waits + 3; e++) begin
      int w;
      w = e - 2;
      if (w >= 0 && w < waits) begin
        RESET_SM  = fin && (w == len - 1);
        error     = (w == e1) || (w == e2);
        BIST_DATA = (w == e1) ? d1 : (w == e2) ? d2 : RESET_SM ? 8'hFF : 8'($urandom);
      end else begin
        RESET_SM  = 1'b0;
        error     = 1'b0;
        BIST_DATA = 8'($urandom);
      end
      chk($sformatf("%s_rb_e%0d", tag, e),   32'(RUNBIST_SELECT), 32'(e <= waits + 1));
      chk($sformatf("%s_done_e%0d", tag, e), 32'(done), 32'(e == waits + 2));
      chk($sformatf("%s_sel_e%0d", tag, e),  32'({GETTEST_SELECT, SETSTATE_SELECT, UPDATEDR}), 32'h0);
      if (e == 1) begin
        chk({tag, "_to_clr"},   32'(timeout), 32'h0);
        chk({tag, "_pass_clr"}, 32'(pass), 32'h0);
        chk({tag, "_fi_clr"},   32'(fail_index), 32'hFF);
      end
      if (e == waits + 3) begin
        chk({tag, "_pass"}, 32'(pass), 32'(!exp_to && exp_fi == 8'hFF));
        chk({tag, "_fi"},   32'(fail_index), 32'(exp_fi));
        chk({tag, "_to"},   32'(timeout), 32'(exp_to));
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_vec"},  32'(vec_count), 32'(exp_vec));
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    int         len, e1, e2;
    logic [7:0] d;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_data  = 8'h00;
    RESET_SM      = 1'b0;
    error         = 1'b0;
    BIST_DATA     = 8'h00;

    do_reset();
    chk_reset_vals("rst");
    chk("rst_ready", 32'(cif.cmd_ready), 32'h1);

    // RUN with nothing loaded
    send(2'b01, 8'h00);
    chk("run0_err",  32'(cmd_err), 32'h1);
    chk("run0_sel",  32'({RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT, UPDATEDR}), 32'h0);
    chk("run0_busy", 32'(busy), 32'h0);
    tick();
    chk("run0_err_clr", 32'(cmd_err), 32'h0);

    // ABORT in IDLE is a no-op
    send(2'b11, 8'h00);
    chk("abort_idle_busy", 32'(busy), 32'h0);
    chk("abort_idle_err",  32'(cmd_err), 32'h0);

    do_load(8'h5A, "ld0");
    do_load(8'h3C, "ld1");
    do_load(8'h96, "ld2");
    while (exp_vec < DEPTH) do_load(8'($urandom), $sformatf("ldf%0d", exp_vec));

    // full memory: LOAD rejected, stay in LOAD_HOLD
    send(2'b00, 8'($urandom));
    chk("full_err",   32'(cmd_err), 32'h1);
    chk("full_upd",   32'(UPDATEDR), 32'h0);
    chk("full_gt",    32'(GETTEST_SELECT), 32'h1);
    chk("full_ready", 32'(cif.cmd_ready), 32'h1);
    chk("full_vec",   32'(vec_count), 32'(DEPTH));
    tick();
    chk("full_err_clr", 32'(cmd_err), 32'h0);

    len = $urandom_range(1, 12);
    do_run(len, -1, 8'h00, -1, 8'h00, 1'b1, "clean");

    len = $urandom_range(3, 10);
    e1  = $urandom_range(0, len - 2);
    e2  = $urandom_range(e1 + 1, len - 1);
    do_run(len, e1, 8'h01, e2, 8'h02, 1'b1, "errrun");

    do_run(0, -1, 8'h00, -1, 8'h00, 1'b0, "tmo");
    tick();
    chk("tmo_sticky", 32'(timeout), 32'h1);
    do_run(TIMEOUT, -1, 8'h00, -1, 8'h00, 1'b1, "edge");

    send(2'b10, 8'h07);
    chk("ss_sel", 32'(SETSTATE_SELECT), 32'h1);
    chk("ss_upd", 32'(UPDATEDR), 32'h1);
    chk("ss_bsr", 32'(BSR), 32'h1C0);
    chk("ss_oth", 32'({RUNBIST_SELECT, GETTEST_SELECT}), 32'h0);
    tick();
    chk("ss_end", 32'({SETSTATE_SELECT, UPDATEDR, busy}), 32'h0);

    // LOAD from IDLE restarts the burst count; SETSTATE from LOAD_HOLD drops GETTEST
    exp_vec = 0;
    do_load(8'($urandom), "ld_re");
    d = 8'($urandom);
    send(2'b10, d);
    chk("hold_ss_gt",  32'(GETTEST_SELECT), 32'h0);
    chk("hold_ss_sel", 32'(SETSTATE_SELECT), 32'h1);
    chk("hold_ss_bsr", 32'(BSR), 32'((d % 16) * 64));
    tick();

    exp_vec = 0;
    do_load(8'($urandom), "ld_ab");
    send(2'b11, 8'h00);
    chk("abort_gt",  32'(GETTEST_SELECT), 32'h0);
    chk("abort_vec", 32'(vec_count), 32'h1);
    chk("abort_rdy", 32'(cif.cmd_ready), 32'h1);

    // TLR in the middle of a RUN
    send(2'b01, 8'h00);
    tick();
    tick();
    chk("mid_rb", 32'(RUNBIST_SELECT), 32'h1);
    TLR = 1'b1;
    tick();
    TLR = 1'b0;
    chk_reset_vals("tlr");
    chk("tlr_ready", 32'(cif.cmd_ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
